rcc_dom_rst_clk_seq: RTL and testbench
======================================

// Module: rcc_dom_rst_clk_seq
// PURPOSE
//  Per-domain reset/clock sequencer for the RCC vcore (one instance per D1/D2/CPU domain).
//  Holds domain reset for a fixed duration once power is good, then releases reset.
//  Enables the domain bus clock a fixed delay after reset release.
//  Reverses the sequence on standby: gate the clock, then assert reset. Also serves software domain-reset pulses.
// PARAMETERS
//  RST_DURATION              10  cycles dom_rst_n held low in RST_HOLD (>=1)
//  CLK_ON_AFTER_RST_RELEASE   8  cycles between dom_rst_n rise and clk_en rise (>=1)
//  GATE_CYCLES                4  cycles between clk_en fall and dom_rst_n fall on standby entry (>=1)
//  CNT_W                      8  delay counter width; must hold max(all three)-1, elaboration error otherwise
// PORTS
//  clk        in   1  RCC kernel clock (rcc_rcc_hclk domain)
//  rst        in   1  synchronous, active-high reset
//  pwr_ok     in   1  domain supply stable (already synchronised)
//  run_req    in   1  level: domain must be active (from PWR/low-power ctrl)
//  sw_rst     in   1  one-cycle pulse: software domain reset (RCC register bit)
//  clk_en     out  1  domain bus-clock gate enable (to clock gate cell)
//  dom_rst_n  out  1  domain reset to bridges/peripherals, active low
//  dom_rdy    out  1  domain clocked and out of reset
//  stby_ack   out  1  domain fully off (clock gated, reset asserted)
//  seq_state  out  3  current state encoding, for status register/debug
// BEHAVIOUR
//  Reset (rst=1 at edge): state=OFF, cnt=0, clk_en=0, dom_rst_n=0, dom_rdy=0, stby_ack=1.
//  All outputs are flops loaded from next-state decode, so they change on the same edge as state. No combinational paths from inputs to outputs.
//  States / outputs (clk_en, dom_rst_n, dom_rdy, stby_ack):
//   OFF      0,0,0,1  run_req&pwr_ok -> RST_HOLD, cnt=0
//   RST_HOLD 0,0,0,0  cnt==RST_DURATION-1 -> CLK_WAIT, cnt=0; else cnt++
//   CLK_WAIT 0,1,0,0  cnt==CLK_ON_AFTER_RST_RELEASE-1 -> RUN; else cnt++
//   RUN      1,1,1,0  !run_req -> GATE, cnt=0
//   GATE     0,1,0,0  cnt==GATE_CYCLES-1 -> OFF; run_req -> CLK_WAIT, cnt=0 (no reset)
//  Priority in every state: pwr_ok=0 (not OFF) > sw_rst > run_req change > counter expiry.
//   pwr_ok=0 -> OFF next edge, from any state.
//   sw_rst in RST_HOLD/CLK_WAIT/RUN -> RST_HOLD with cnt=0: clk_en and dom_rst_n fall together. sw_rst in OFF/GATE is ignored.
//  run_req dropping in RST_HOLD/CLK_WAIT does not abort the sequence: it completes to RUN, then goes to GATE next edge.
//  Latency: run_req&pwr_ok sampled at edge 0 ->
//   dom_rst_n=1 at edge RST_DURATION+1;
//   clk_en=dom_rdy=1 at edge RST_DURATION+CLK_ON_AFTER_RST_RELEASE+1.
//  Standby: run_req=0 sampled at edge 0 -> clk_en=0 at edge 1; dom_rst_n=0, stby_ack=1 at edge GATE_CYCLES+1.
//  Invariant: clk_en=1 implies dom_rst_n=1. dom_rst_n never falls while clk_en=1 except on sw_rst or pwr_ok loss.
//  Counter saturates, never wraps. It is cleared on every state entry.
//  Unused state codes -> OFF next edge.
// STRUCTURE
//  Shared header rcc_seq_defines.vh: state codes OFF=0, RST_HOLD=1, CLK_WAIT=2, RUN=3, GATE=4. RCC status regs reuse these codes.
//  Sub-module rcc_dly_cnt #(CNT_W): load/clear, increment, terminal-compare against a runtime limit.
//  rcc_dly_cnt is shared with later sequencers.
//  Top: FSM plus output flops. Instantiated in rcc_sys_clk_rst_ctrl with D1/D2 RST_DURATION and CLK_ON_AFTER_*_RST_RELEASE.
// TESTING
//  1 Power-up, defaults: rst released, pwr_ok=run_req=1 at edge 0 -> dom_rst_n=1 @11; clk_en=dom_rdy=1 @19; stby_ack=0 @1.
//  2 sw_rst pulse in RUN at edge 30 -> clk_en=dom_rst_n=0 @31; dom_rst_n=1 @41; clk_en=1 @49.
//  3 run_req=0 in RUN at edge 50 -> clk_en=0,dom_rdy=0 @51; dom_rst_n=0,stby_ack=1 @55.
//  4 run_req re-raised at 2nd GATE cycle -> CLK_WAIT, dom_rst_n stays 1; clk_en=1 8 edges later.
//  5 pwr_ok=0 during RST_HOLD, and separately during RUN -> OFF next edge. Same edge as sw_rst -> OFF wins.
//  6 rst=1 mid-CLK_WAIT -> all outputs at reset values next edge. Assertion checks clk_en->dom_rst_n throughout all runs.

Source files
------------

// File: rtl/rcc_dom_rst_clk_seq_pkg.sv
// Shared definitions for the per-domain reset/clock sequencer.
// The state codes are also used by the RCC status registers, so they must not be renumbered.
package rcc_dom_rst_clk_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_CLK_WAIT = 3'd2,
    ST_RUN      = 3'd3,
    ST_GATE     = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic clk_en;
    logic dom_rst_n;
    logic dom_rdy;
    logic stby_ack;
  } seq_out_t;

  localparam seq_out_t OUT_OFF  = '{clk_en: 1'b0, dom_rst_n: 1'b0, dom_rdy: 1'b0, stby_ack: 1'b1};
  localparam seq_out_t OUT_HOLD = '{clk_en: 1'b0, dom_rst_n: 1'b0, dom_rdy: 1'b0, stby_ack: 1'b0};
  localparam seq_out_t OUT_WAIT = '{clk_en: 1'b0, dom_rst_n: 1'b1, dom_rdy: 1'b0, stby_ack: 1'b0};
  localparam seq_out_t OUT_RUN  = '{clk_en: 1'b1, dom_rst_n: 1'b1, dom_rdy: 1'b1, stby_ack: 1'b0};

  function automatic seq_out_t seq_outputs(input seq_state_e st);
    seq_out_t o;
    case (st)
      ST_OFF:      o = OUT_OFF;
      ST_RST_HOLD: o = OUT_HOLD;
      ST_CLK_WAIT: o = OUT_WAIT;
      ST_RUN:      o = OUT_RUN;
      ST_GATE:     o = OUT_WAIT;
      default:     o = OUT_OFF;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rcc_dly_cnt.sv
// Saturating delay counter with clear, increment and a terminal compare against a runtime limit.
// Kept generic so later sequencers can reuse it with their own limits.
module rcc_dly_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear wins over increment, and the count holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == limit);

endmodule

// File: rtl/rcc_dom_rst_clk_seq_chk.sv
// Protocol checker for the domain sequencer: the clock is never enabled into a held reset,
// and reset only drops under a running clock on software reset, supply loss or block reset.
module rcc_dom_rst_clk_seq_chk (
  input logic clk,
  input logic rst,
  input logic pwr_ok,
  input logic sw_rst,
  input logic clk_en,
  input logic dom_rst_n
);

  a_clk_implies_rst_rel: assert property (@(posedge clk) clk_en |-> dom_rst_n)
    else $error("clk_en high while dom_rst_n low");

  a_no_rst_under_clk: assert property (@(posedge clk)
    ($fell(dom_rst_n) && $past(clk_en)) |-> $past(sw_rst || !pwr_ok || rst))
    else $error("dom_rst_n fell under a running clock without cause");

endmodule

// File: rtl/rcc_dom_rst_clk_seq.sv
// Per-domain reset/clock sequencer: reset hold, reset release, clock enable, and the reverse on standby.
// Every output is a flop loaded from the next-state decode, so nothing is combinational from inputs.
module rcc_dom_rst_clk_seq
  import rcc_dom_rst_clk_seq_pkg::*;
#(
  parameter int RST_DURATION             = 10,
  parameter int CLK_ON_AFTER_RST_RELEASE = 8,
  parameter int GATE_CYCLES              = 4,
  parameter int CNT_W                    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_ok,
  input  logic       run_req,
  input  logic       sw_rst,
  output logic       clk_en,
  output logic       dom_rst_n,
  output logic       dom_rdy,
  output logic       stby_ack,
  output logic [2:0] seq_state
);

  if ((RST_DURATION < 1) || (CLK_ON_AFTER_RST_RELEASE < 1) || (GATE_CYCLES < 1) ||
      ((RST_DURATION - 1) >= (1 << CNT_W)) ||
      ((CLK_ON_AFTER_RST_RELEASE - 1) >= (1 << CNT_W)) ||
      ((GATE_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_param
    $error("rcc_dom_rst_clk_seq: delay parameters must be >=1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LIM_RST  = CNT_W'(RST_DURATION - 1);
  localparam logic [CNT_W-1:0] LIM_CLK  = CNT_W'(CLK_ON_AFTER_RST_RELEASE - 1);
  localparam logic [CNT_W-1:0] LIM_GATE = CNT_W'(GATE_CYCLES - 1);

  seq_state_e       state_r;
  seq_state_e       state_nx_s;
  seq_out_t         out_r;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic [CNT_W-1:0] cnt_lim_s;
  logic             cnt_done_s;

  rcc_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .inc   (cnt_inc_s),
    .limit (cnt_lim_s),
    .done  (cnt_done_s)
  );

  // Next-state decode; priority is supply loss, then software reset, then run_req, then counter expiry.
  always_comb begin
    state_nx_s = state_r;
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    cnt_lim_s  = {CNT_W{1'b0}};
    case (state_r)
      ST_OFF: begin
        cnt_clr_s = 1'b1;
        if (run_req && pwr_ok) begin
          state_nx_s = ST_RST_HOLD;
        end else begin
          state_nx_s = ST_OFF;
        end
      end
      ST_RST_HOLD: begin
        cnt_lim_s = LIM_RST;
        if (!pwr_ok) begin
          state_nx_s = ST_OFF;
          cnt_clr_s  = 1'b1;
        end else if (sw_rst) begin
          state_nx_s = ST_RST_HOLD;
          cnt_clr_s  = 1'b1;
        end else if (cnt_done_s) begin
          state_nx_s = ST_CLK_WAIT;
          cnt_clr_s  = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      // A run_req drop here is deliberately ignored; RUN hands it to GATE one edge later.
      ST_CLK_WAIT: begin
        cnt_lim_s = LIM_CLK;
        if (!pwr_ok) begin
          state_nx_s = ST_OFF;
          cnt_clr_s  = 1'b1;
        end else if (sw_rst) begin
          state_nx_s = ST_RST_HOLD;
          cnt_clr_s  = 1'b1;
        end else if (cnt_done_s) begin
          state_nx_s = ST_RUN;
          cnt_clr_s  = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_clr_s = 1'b1;
        if (!pwr_ok) begin
          state_nx_s = ST_OFF;
        end else if (sw_rst) begin
          state_nx_s = ST_RST_HOLD;
        end else if (!run_req) begin
          state_nx_s = ST_GATE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_GATE: begin
        cnt_lim_s = LIM_GATE;
        if (!pwr_ok) begin
          state_nx_s = ST_OFF;
          cnt_clr_s  = 1'b1;
        end else if (run_req) begin
          state_nx_s = ST_CLK_WAIT;
          cnt_clr_s  = 1'b1;
        end else if (cnt_done_s) begin
          state_nx_s = ST_OFF;
          cnt_clr_s  = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      default: begin
        state_nx_s = ST_OFF;
        cnt_clr_s  = 1'b1;
      end
    endcase
  end

  // State and output flops; outputs are decoded from the next state so they move with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_OFF;
      out_r   <= OUT_OFF;
    end else begin
      state_r <= state_nx_s;
      out_r   <= seq_outputs(state_nx_s);
    end
  end

  assign clk_en    = out_r.clk_en;
  assign dom_rst_n = out_r.dom_rst_n;
  assign dom_rdy   = out_r.dom_rdy;
  assign stby_ack  = out_r.stby_ack;
  assign seq_state = state_r;

endmodule

// File: tb/tb_rcc_dom_rst_clk_seq.sv
// Directed bench for the domain sequencer: a stimulus table drives inputs at absolute edges,
// expected outputs are queued up front, and a negedge monitor pops and compares them.
module tb_rcc_dom_rst_clk_seq;
  import rcc_dom_rst_clk_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst, pwr_ok, run_req, sw_rst;
  logic       clk_en, dom_rst_n, dom_rdy, stby_ack;
  logic [2:0] seq_state;

  typedef struct {
    int         tgt;
    logic [6:0] exp;
    string      nm;
  } exp_t;

  typedef struct {
    int   k;
    logic r, p, q, s;
  } drv_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   base = 0;
  int   compared = 0;
  int   failed = 0;
  logic [6:0] act;

  localparam logic [3:0] O_OFF  = 4'b0001;
  localparam logic [3:0] O_HOLD = 4'b0000;
  localparam logic [3:0] O_WAIT = 4'b0100;
  localparam logic [3:0] O_RUN  = 4'b1110;

  rcc_dom_rst_clk_seq dut (
    .clk       (clk),
    .rst       (rst),
    .pwr_ok    (pwr_ok),
    .run_req   (run_req),
    .sw_rst    (sw_rst),
    .clk_en    (clk_en),
    .dom_rst_n (dom_rst_n),
    .dom_rdy   (dom_rdy),
    .stby_ack  (stby_ack),
    .seq_state (seq_state)
  );

  rcc_dom_rst_clk_seq_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .pwr_ok    (pwr_ok),
    .sw_rst    (sw_rst),
    .clk_en    (clk_en),
    .dom_rst_n (dom_rst_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int k, input logic [2:0] st, input logic [3:0] o, input string nm);
    exp_t x;
    x.tgt = base + k;
    x.exp = {st, o};
    x.nm  = nm;
    sb.push_back(x);
  endtask

  task automatic wait_edge(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every queued expectation whose edge has been reached.
  always @(negedge clk) begin
    act = {seq_state, clk_en, dom_rst_n, dom_rdy, stby_ack};
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      e = sb.pop_front();
      compared++;
      if (e.tgt != cyc) begin
        failed++;
        $display("FAIL %s: expected at edge %0d, checked late at %0d", e.nm, e.tgt, cyc);
      end else if (act !== e.exp) begin
        failed++;
        $display("FAIL %s @%0d: got st=%0d ce/rn/rdy/ack=%b, want st=%0d ce/rn/rdy/ack=%b",
                 e.nm, e.tgt - base, act[6:4], act[3:0], e.exp[6:4], e.exp[3:0]);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    drv_t drv[$];
    drv = '{
      '{0,   1'b0, 1'b1, 1'b1, 1'b0},   // power-up request
      '{30,  1'b0, 1'b1, 1'b1, 1'b1},   // sw_rst pulse in RUN
      '{31,  1'b0, 1'b1, 1'b1, 1'b0},
      '{50,  1'b0, 1'b1, 1'b0, 1'b0},   // standby
      '{60,  1'b0, 1'b1, 1'b1, 1'b0},
      '{80,  1'b0, 1'b1, 1'b0, 1'b0},
      '{82,  1'b0, 1'b1, 1'b1, 1'b0},   // re-raise in second GATE cycle
      '{95,  1'b0, 1'b0, 1'b1, 1'b0},   // supply loss in RUN
      '{100, 1'b0, 1'b1, 1'b1, 1'b0},
      '{105, 1'b0, 1'b0, 1'b1, 1'b0},   // supply loss in RST_HOLD
      '{110, 1'b0, 1'b1, 1'b1, 1'b0},
      '{132, 1'b0, 1'b0, 1'b1, 1'b1},   // supply loss together with sw_rst
      '{133, 1'b0, 1'b0, 1'b1, 1'b0},
      '{140, 1'b0, 1'b1, 1'b1, 1'b0},
      '{143, 1'b0, 1'b1, 1'b0, 1'b0},   // run_req drop during RST_HOLD
      '{161, 1'b0, 1'b1, 1'b1, 1'b0},
      '{165, 1'b1, 1'b1, 1'b1, 1'b0},   // block reset mid CLK_WAIT
      '{166, 1'b0, 1'b1, 1'b1, 1'b0}
    };

    rst = 1'b1; pwr_ok = 1'b1; run_req = 1'b1; sw_rst = 1'b0;
    @(posedge clk); #1;
    base = cyc;
    ex(1, ST_OFF, O_OFF, "reset_a");
    ex(2, ST_OFF, O_OFF, "reset_b");
    wait_edge(2);

    base = cyc;
    ex(1,   ST_RST_HOLD, O_HOLD, "pu_stby_drop");
    ex(10,  ST_RST_HOLD, O_HOLD, "pu_hold_last");
    ex(11,  ST_CLK_WAIT, O_WAIT, "pu_rst_rel");
    ex(18,  ST_CLK_WAIT, O_WAIT, "pu_clk_wait_last");
    ex(19,  ST_RUN,      O_RUN,  "pu_run");
    ex(30,  ST_RUN,      O_RUN,  "run_steady");
    ex(31,  ST_RST_HOLD, O_HOLD, "swrst_fall");
    ex(40,  ST_RST_HOLD, O_HOLD, "swrst_hold_last");
    ex(41,  ST_CLK_WAIT, O_WAIT, "swrst_rst_rel");
    ex(48,  ST_CLK_WAIT, O_WAIT, "swrst_wait_last");
    ex(49,  ST_RUN,      O_RUN,  "swrst_run");
    ex(51,  ST_GATE,     O_WAIT, "stby_clk_off");
    ex(54,  ST_GATE,     O_WAIT, "stby_gate_last");
    ex(55,  ST_OFF,      O_OFF,  "stby_ack");
    ex(79,  ST_RUN,      O_RUN,  "rerun");
    ex(81,  ST_GATE,     O_WAIT, "gate_1st");
    ex(82,  ST_GATE,     O_WAIT, "gate_2nd");
    ex(83,  ST_CLK_WAIT, O_WAIT, "gate_abort");
    ex(90,  ST_CLK_WAIT, O_WAIT, "abort_wait_last");
    ex(91,  ST_RUN,      O_RUN,  "abort_run");
    ex(96,  ST_OFF,      O_OFF,  "pwr_loss_run");
    ex(101, ST_RST_HOLD, O_HOLD, "pwr_back");
    ex(106, ST_OFF,      O_OFF,  "pwr_loss_hold");
    ex(129, ST_RUN,      O_RUN,  "run_again");
    ex(133, ST_OFF,      O_OFF,  "pwr_beats_swrst");
    ex(141, ST_RST_HOLD, O_HOLD, "hold_start");
    ex(144, ST_RST_HOLD, O_HOLD, "hold_no_abort");
    ex(151, ST_CLK_WAIT, O_WAIT, "hold_completes");
    ex(159, ST_RUN,      O_RUN,  "run_then_gate");
    ex(160, ST_GATE,     O_WAIT, "late_gate");
    ex(162, ST_CLK_WAIT, O_WAIT, "gate_to_wait");
    ex(166, ST_OFF,      O_OFF,  "rst_mid_wait");
    ex(167, ST_RST_HOLD, O_HOLD, "after_rst");

    foreach (drv[i]) begin
      wait_edge(drv[i].k);
      rst     = drv[i].r;
      pwr_ok  = drv[i].p;
      run_req = drv[i].q;
      sw_rst  = drv[i].s;
    end

    wait_edge(172);
    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      failed++;
      $display("FAIL %s: expectation for edge %0d never checked", e.nm, e.tgt - base);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
